// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = 3;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Handshake bundle between the requesters (master) and the arbiter (slave).
// Latency: n/a (wires only).
// Backpressure: n/a; the arbiter drives grant, the requesters drive req/done/ena.
//   ena          requester side -> arbiter, enables new grants
//   req[7:0]     level-sensitive request per requester
//   done         one-cycle release strobe from the grant holder
//   grant[7:0]   one-hot grant, zero when idle
//   grant_valid  high while a grant is held
//   grant_idx    binary index of the holder
//   timeout      one-cycle pulse when the watchdog revokes a grant
interface rr_arbiter_8_if;
    import arb_pkg::*;

    logic                 ena;
    logic [ARB_N-1:0]     req;
    logic                 done;
    logic [ARB_N-1:0]     grant;
    logic                 grant_valid;
    logic [ARB_IDX_W-1:0] grant_idx;
    logic                 timeout;

    modport master (
        output ena, req, done,
        input  grant, grant_valid, grant_idx, timeout
    );

    modport slave (
        input  ena, req, done,
        output grant, grant_valid, grant_idx, timeout
    );

endinterface

// File: rtl/decoder_3_to_8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
// Latency: combinational.
// Backpressure: none.
//   ena  in  1  output enable
//   in   in  3  binary index
//   out  out 8  one-hot of in when ena, else zero
module decoder_3_to_8 (
    input  logic       ena,
    input  logic [2:0] in,
    output logic [7:0] out
);

    always_comb begin
        out = '0;
        if (ena) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter: one shared resource among 8 requesters, grant held until release.
// Latency: request seen at an edge is granted by that edge; one idle cycle between grants.
// Backpressure: ena=0 blocks new grants without revoking a held one; requesters wait on req.
//   clk, rst     clock and synchronous active-high reset
//   arb (slave)  ena, req, done in; grant, grant_valid, grant_idx, timeout out
// Optional feature: define ARB_WATCHDOG_EN to revoke grants held for MAX_HOLD cycles.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter logic [ARB_IDX_W-1:0] PTR_RESET = 3'd0,
    parameter int                   MAX_HOLD  = 16
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_8_if.slave  arb
);

    arb_state_t           state, state_nxt;
    logic [ARB_IDX_W-1:0] ptr, ptr_nxt;
    logic [ARB_IDX_W-1:0] idx_q, idx_nxt;
    logic                 timeout_q, timeout_nxt;
    logic                 grant_vld;
    logic [ARB_N-1:0]     grant_w;
    logic                 user_rel;
    logic                 wd_fire;

    // First asserted request scanning ptr, ptr+1, ... with 3-bit wrap.
    function automatic logic [ARB_IDX_W-1:0] rr_pick(
        input logic [ARB_N-1:0]     r,
        input logic [ARB_IDX_W-1:0] p
    );
        logic                 found;
        logic [ARB_IDX_W-1:0] cand;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < ARB_N; k++) begin
            cand = p + ARB_IDX_W'(k);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    assign grant_vld = (state == S_GRANT);
    // Holder strobed done, or withdrew its request.
    assign user_rel  = arb.done || !arb.req[idx_q];

`ifdef ARB_WATCHDOG_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Held at zero while idle, so it is clear on every entry to S_GRANT.
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign wd_fire = grant_vld && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    // MAX_HOLD only matters when the watchdog is built in.
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
    assign wd_fire         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= PTR_RESET;
            idx_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            idx_q     <= idx_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = idx_q;
        timeout_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb.ena && |arb.req) begin
                    idx_nxt   = rr_pick(arb.req, ptr);
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (user_rel || wd_fire) begin
                    ptr_nxt     = idx_q + 1'b1;
                    state_nxt   = S_IDLE;
                    // Only flag a revoke the holder did not ask for itself.
                    timeout_nxt = wd_fire && !user_rel;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    decoder_3_to_8 u_dec (
        .ena (grant_vld),
        .in  (idx_q),
        .out (grant_w)
    );

    assign arb.grant       = grant_w;
    assign arb.grant_valid = grant_vld;
    assign arb.grant_idx   = idx_q;
    assign arb.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];
    int   to_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] prev_grant = 8'h00;

    rr_arbiter_8_if ifc ();

    rr_arbiter_8 #(.PTR_RESET(3'd0), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .arb (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (ifc.grant_valid) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no grant within 16 cycles, got 0 expected 1", name);
        end
    endtask

    task automatic pulse_done(input logic [7:0] req_after);
        ifc.done = 1'b1;
        ifc.req  = req_after;
        cyc();
        ifc.done = 1'b0;
    endtask

    // Scoreboard monitor: pops an expected winner on each new grant.
    always @(negedge clk) begin
        int e;
        chk("onehot0", 32'($onehot0(ifc.grant)), 32'd1);
        chk("valid_eq_or", 32'(ifc.grant_valid), 32'(|ifc.grant));
        if (ifc.grant_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant: got %0h expected none", ifc.grant);
            end else begin
                e = exp_q.pop_front();
                chk("grant", 32'(ifc.grant), 32'(8'h01 << e));
                chk("grant_idx", 32'(ifc.grant_idx), 32'(e));
            end
        end
        if (ifc.grant_valid && prev_valid) begin
            chk("grant_frozen", 32'(ifc.grant), 32'(prev_grant));
        end
`ifdef ARB_WATCHDOG_EN
        if (ifc.timeout) begin
            to_cnt++;
            chk("timeout_on_drop", 32'({prev_valid, ifc.grant_valid}), 32'(2'b10));
        end
`else
        chk("timeout_tied", 32'(ifc.timeout), 32'd0);
`endif
        prev_valid = ifc.grant_valid;
        prev_grant = ifc.grant;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst      = 1'b1;
        ifc.ena  = 1'b0;
        ifc.req  = 8'h00;
        ifc.done = 1'b0;
        cyc();
        chk("rst_valid", 32'(ifc.grant_valid), 32'd0);
        chk("rst_idx", 32'(ifc.grant_idx), 32'd0);
        chk("rst_timeout", 32'(ifc.timeout), 32'd0);
        cyc();
        rst     = 1'b0;
        ifc.ena = 1'b1;

        // 1: idle with no requests
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_grant", 32'(ifc.grant), 32'd0);
        end

        // 2: 0x81 from ptr 0 -> 0 then 7, ptr wraps back to 0
        exp_q.push_back(0);
        exp_q.push_back(7);
        exp_q.push_back(0);
        ifc.req = 8'h81;
        wait_grant("t2_first");
        pulse_done(8'h81);
        chk("t2_bubble", 32'(ifc.grant_valid), 32'd0);
        wait_grant("t2_second");
        pulse_done(8'h00);
        ifc.req = 8'h81;
        wait_grant("t2_wrap");
        pulse_done(8'h00);

        // 3: all requesting, fresh ptr -> 0..7,0 with one bubble each
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int g = 0; g < 9; g++) exp_q.push_back(g % 8);
        ifc.req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            wait_grant("t3_grant");
            chk("t3_idx", 32'(ifc.grant_idx), 32'(g % 8));
            pulse_done((g == 8) ? 8'h00 : 8'hFF);
            chk("t3_bubble", 32'(ifc.grant_valid), 32'd0);
            if (g < 8) begin
                cyc();
                chk("t3_regrant", 32'(ifc.grant_valid), 32'd1);
            end
        end

        // 4: ptr=1, idx 3 held across ena=0, withdrawn, blocked, then idx 4
        exp_q.push_back(3);
        ifc.req = 8'h08;
        wait_grant("t4_grant3");
        ifc.ena = 1'b0;
        cyc();
        chk("t4_hold_ena0", 32'(ifc.grant), 32'h08);
        ifc.req = 8'h00;
        cyc();
        chk("t4_withdrawn", 32'(ifc.grant), 32'h00);
        ifc.req = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_blocked", 32'(ifc.grant_valid), 32'd0);
        end
        exp_q.push_back(4);
        ifc.ena = 1'b1;
        wait_grant("t4_grant4");
        chk("t4_idx4", 32'(ifc.grant_idx), 32'd4);

        // 5: reset with done while grant 0x10 held
        chk("t5_pre", 32'(ifc.grant), 32'h10);
        rst      = 1'b1;
        ifc.done = 1'b1;
        cyc();
        chk("t5_grant", 32'(ifc.grant), 32'h00);
        chk("t5_idx", 32'(ifc.grant_idx), 32'd0);
        rst      = 1'b0;
        ifc.done = 1'b0;
        exp_q.push_back(0);
        wait_grant("t5_regrant");
        chk("t5_ptr_reset", 32'(ifc.grant_idx), 32'd0);
        pulse_done(8'h00);

        // 6: single holder, never releases
        exp_q.push_back(2);
`ifdef ARB_WATCHDOG_EN
        exp_q.push_back(2);
        ifc.req = 8'h04;
        wait_grant("t6_grant");
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_held", 32'(ifc.grant), 32'h04);
        end
        cyc();
        chk("t6_dropped", 32'(ifc.grant_valid), 32'd0);
        chk("t6_timeout", 32'(ifc.timeout), 32'd1);
        cyc();
        chk("t6_regrant", 32'(ifc.grant), 32'h04);
        chk("t6_timeout_off", 32'(ifc.timeout), 32'd0);
        pulse_done(8'h00);
        cyc();
        chk("t6_pulse_count", 32'(to_cnt), 32'd1);
`else
        ifc.req = 8'h04;
        wait_grant("t6_grant");
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("t6_held", 32'(ifc.grant), 32'h04);
        end
        pulse_done(8'h00);
`endif

        cyc();
        cyc();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
